regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single register-file write port between two writeback requesters: port A for ALU results and port B for load data. It registers the winning write onto the `regWrite`/`regDest`/`writeData` inputs of the register file. It also keeps a pending-write scoreboard (busy bit per register), so issue logic can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file, alongside decode/issue.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers (address width = log2(NREG) = 5)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- a_valid  in  1  port A (ALU) has a write pending
- a_rd  in  5  port A destination register
- a_data  in  XLEN  port A write data
- a_ready  out  1  port A granted this cycle (handshake = a_valid & a_ready)
- b_valid, b_rd, b_data, b_ready  same as port A, for port B (load unit)
- issue_valid  in  1  decode wants to issue an instruction
- issue_rd  in  5  destination of the issuing instruction (0 = no destination)
- rs1, rs2  in  5  sources of the issuing instruction
- issue_stall  out  1  issue must be held this cycle
- regWrite  out  1  register-file write enable
- regDest  out  5  register-file write address
- writeData  out  XLEN  register-file write data
- busy  out  NREG  scoreboard vector; bit 0 is constant 0

## Operation
- Arbitration:
  - At most one grant per cycle. `a_ready`/`b_ready` are combinational from the valids and the round-robin pointer.
  - Only one valid: that port is granted.
  - Both valid: the port named by `rr_ptr` is granted, and `rr_ptr` toggles to the losing port.
  - With a single requester, `rr_ptr` is unchanged.
- Output register: on the grant edge, load `regDest <= rd`, `writeData <= data`, and `regWrite <= (rd != 0)`.
  - With no grant, `regWrite <= 0`; `regDest` and `writeData` hold their values.
- x0 writes: always accepted (ready asserted) but dropped. `regWrite` stays 0.
- Scoreboard set: on an edge where `issue_valid & !issue_stall & issue_rd != 0`, `busy[issue_rd] <= 1`.
- Scoreboard clear: on the grant edge for rd, `busy[rd] <= 0`. Granted writes to non-busy registers are legal and perform the write normally.
- Stall: `issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[issue_rd])`. It is computed from registered `busy` only; there is no forwarding of same-cycle clears.
- Set and clear of the same register on one edge cannot occur, because WAW stalls issue. If both are forced, set wins.
- Set and clear of different registers on one edge: both take effect.

## Timing
- Reset values: `regWrite`=0, `regDest`=0, `writeData`=0, `busy`=0, `rr_ptr`=A. `a_ready`/`b_ready` are combinational, so they are 0 when no valid is asserted.
- Reset asserted mid-operation: all pending state is discarded immediately. Any in-flight grant is lost; requesters re-present after reset.
- Latency, handshake to `regWrite` high: 1 cycle. The register file writes on the falling edge of that cycle.
- Busy clears on the same edge that raises `regWrite`. An instruction reading that register can therefore issue in the cycle `regWrite` is high, and reads the new value after the negedge write.
- Requesters hold valid, rd and data stable until ready. Ready may assert in the same cycle valid rises.
- Throughput: one write per cycle. With both ports continuously valid, grants strictly alternate A,B,A,B.

## Structure
- Shared package `regfile_pkg`: XLEN, NREG, REG_ADDR_W=5, a typedef for a register address, a typedef for a write-request struct {valid, rd, data}, and a `PORT_A`/`PORT_B` enum for the pointer.
- Sub-module `rr_arbiter2`: a two-requester round-robin arbiter with its own pointer flop. Inputs: `clock`, `reset`, two requests. Outputs: two one-hot grants.
- The top level holds the output register, scoreboard and stall logic.

## Test plan
- Reset mid-stream with `busy`=0x0000_0006 and `regWrite`=1 -> all outputs 0 and `busy`=0 asynchronously; `rr_ptr`=A afterwards.
- A only: rd=5, data=0xDEADBEEF -> `a_ready`=1 the same cycle. Next cycle `regWrite`=1, `regDest`=5, `writeData`=0xDEADBEEF. The following cycle `regWrite`=0.
- A and B valid continuously for 4 cycles (rd=3/4) -> grants A,B,A,B. Writes to 3,4,3,4 appear one cycle delayed; each port waits at most 1 cycle.
- Issue rd=7 -> `busy[7]`=1. Issue with rs1=7 -> `issue_stall`=1. Port B writes rd=7 -> `busy[7]` clears on the grant edge, and the stall drops in the cycle `regWrite`=1.
- Issue rd=9 while `busy[9]`=1 -> `issue_stall`=1 (WAW); `busy` unchanged.
- Port A writes rd=0 with data=0x1234 -> `a_ready`=1, `regWrite` stays 0, `busy[0]` stays 0. Issue with rd=0 never stalls.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback arbiter.
// Widths, register address type, write request bundle, pointer enum.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic            valid;
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wr_req_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with its own pointer flop.
// Pointer moves to the loser only when both requesters contend.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    port_e ptr_q, ptr_d;

    always_comb begin
        gnt_a_o = req_a_i & (~req_b_i | (ptr_q == PORT_A));
        gnt_b_o = req_b_i & (~req_a_i | (ptr_q == PORT_B));
        ptr_d   = ptr_q;
        if (req_a_i && req_b_i) begin
            ptr_d = gnt_a_o ? PORT_B : PORT_A;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B).
// Registers the winning write and tracks pending writes per register.
module regfile_wb_arbiter #(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    input  regfile_pkg::reg_addr_t a_rd,
    input  logic [XLEN-1:0]       a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  regfile_pkg::reg_addr_t b_rd,
    input  logic [XLEN-1:0]       b_data,
    output logic                  b_ready,
    input  logic                  issue_valid,
    input  regfile_pkg::reg_addr_t issue_rd,
    input  regfile_pkg::reg_addr_t rs1,
    input  regfile_pkg::reg_addr_t rs2,
    output logic                  issue_stall,
    output logic                  regWrite,
    output regfile_pkg::reg_addr_t regDest,
    output logic [XLEN-1:0]       writeData,
    output logic [NREG-1:0]       busy
);

    import regfile_pkg::*;

    logic            gnt_a, gnt_b;
    logic            issue_set;
    wr_req_t         win;

    logic            regWrite_q, regWrite_d;
    reg_addr_t       regDest_q, regDest_d;
    logic [XLEN-1:0] writeData_q, writeData_d;
    logic [NREG-1:0] busy_q, busy_d;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    always_comb begin
        win = '0;
        if (gnt_a) begin
            win = '{valid: 1'b1, rd: a_rd, data: a_data};
        end else if (gnt_b) begin
            win = '{valid: 1'b1, rd: b_rd, data: b_data};
        end
    end

    // Stall looks only at registered busy; same-edge clears are not forwarded.
    assign issue_stall = issue_valid &
                         (busy_q[rs1] | busy_q[rs2] | busy_q[issue_rd]);
    assign issue_set   = issue_valid & ~issue_stall & (issue_rd != '0);

    always_comb begin
        regWrite_d  = 1'b0;
        regDest_d   = regDest_q;
        writeData_d = writeData_q;
        busy_d      = busy_q;
        if (win.valid) begin
            regWrite_d         = (win.rd != '0);
            regDest_d          = win.rd;
            writeData_d        = win.data;
            busy_d[win.rd]     = 1'b0;
        end
        // Set is applied after clear so it wins on the same register.
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regWrite_q  <= 1'b0;
            regDest_q   <= '0;
            writeData_q <= '0;
            busy_q      <= '0;
        end else begin
            regWrite_q  <= regWrite_d;
            regDest_q   <= regDest_d;
            writeData_q <= writeData_d;
            busy_q      <= busy_d;
        end
    end

    assign regWrite  = regWrite_q;
    assign regDest   = regDest_q;
    assign writeData = writeData_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change 1ns after posedge; checks land 1-2ns after posedge.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, issue_stall, regWrite;
    logic [4:0]  regDest;
    logic [31:0] writeData, busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .issue_stall (issue_stall),
        .regWrite    (regWrite),
        .regDest     (regDest),
        .writeData   (writeData),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; issue_valid = 0;
        a_rd = 0; b_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        a_data = 0; b_data = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_regDest", {27'd0, regDest}, 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
        reset = 0;

        // A only
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        #1;
        chk("aonly_ready", {30'd0, a_ready, b_ready}, 32'd2);
        tick();
        idle();
        chk("aonly_we", {31'd0, regWrite}, 32'd1);
        chk("aonly_dest", {27'd0, regDest}, 32'd5);
        chk("aonly_data", writeData, 32'hDEADBEEF);
        chk("aonly_busy", busy, 32'd0);
        tick();
        chk("aonly_we_low", {31'd0, regWrite}, 32'd0);
        chk("aonly_dest_hold", {27'd0, regDest}, 32'd5);

        // Both valid: strict alternation A,B,A,B
        a_valid = 1; a_rd = 3; a_data = 32'h33;
        b_valid = 1; b_rd = 4; b_data = 32'h44;
        #1;
        chk("rr0_ready", {30'd0, a_ready, b_ready}, 32'd2);
        tick();
        #1;
        chk("rr1_ready", {30'd0, a_ready, b_ready}, 32'd1);
        chk("rr1_dest", {27'd0, regDest}, 32'd3);
        chk("rr1_data", writeData, 32'h33);
        tick();
        #1;
        chk("rr2_ready", {30'd0, a_ready, b_ready}, 32'd2);
        chk("rr2_dest", {27'd0, regDest}, 32'd4);
        chk("rr2_data", writeData, 32'h44);
        tick();
        #1;
        chk("rr3_ready", {30'd0, a_ready, b_ready}, 32'd1);
        chk("rr3_dest", {27'd0, regDest}, 32'd3);
        tick();
        idle();
        chk("rr4_dest", {27'd0, regDest}, 32'd4);
        chk("rr4_we", {31'd0, regWrite}, 32'd1);

        // RAW: issue rd=7, then a reader of x7 stalls until B writes x7
        issue_valid = 1; issue_rd = 7;
        #1;
        chk("raw_issue_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        issue_rd = 0; rs1 = 7;
        chk("raw_busy7", busy, 32'h0000_0080);
        #1;
        chk("raw_stall", {31'd0, issue_stall}, 32'd1);
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        #1;
        chk("raw_b_ready", {30'd0, a_ready, b_ready}, 32'd1);
        chk("raw_stall_same", {31'd0, issue_stall}, 32'd1);
        tick();
        b_valid = 0;
        chk("raw_busy_clr", busy, 32'd0);
        chk("raw_we", {31'd0, regWrite}, 32'd1);
        chk("raw_dest", {27'd0, regDest}, 32'd7);
        chk("raw_stall_drop", {31'd0, issue_stall}, 32'd0);
        tick();
        idle();

        // WAW: second issue to x9 stalls and leaves busy unchanged
        issue_valid = 1; issue_rd = 9;
        tick();
        chk("waw_busy9", busy, 32'h0000_0200);
        #1;
        chk("waw_stall", {31'd0, issue_stall}, 32'd1);
        tick();
        chk("waw_busy_same", busy, 32'h0000_0200);

        // Set x10 and clear x9 on the same edge
        issue_rd = 10;
        b_valid = 1; b_rd = 9; b_data = 32'h99;
        #1;
        chk("setclr_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        idle();
        chk("setclr_busy", busy, 32'h0000_0400);

        // x0 write: accepted, dropped
        a_valid = 1; a_rd = 0; a_data = 32'h1234;
        issue_valid = 1; issue_rd = 0;
        #1;
        chk("x0_ready", {30'd0, a_ready, b_ready}, 32'd2);
        chk("x0_issue_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        idle();
        chk("x0_we", {31'd0, regWrite}, 32'd0);
        chk("x0_busy", busy, 32'h0000_0400);

        // Build busy=0x6, regWrite=1, pointer at B, then reset mid-cycle
        issue_valid = 1; issue_rd = 1;
        tick();
        issue_rd = 2;
        a_valid = 1; a_rd = 10; a_data = 32'hAA;
        b_valid = 1; b_rd = 11; b_data = 32'hBB;
        tick();
        idle();
        chk("pre_rst_busy", busy, 32'h0000_0006);
        chk("pre_rst_we", {31'd0, regWrite}, 32'd1);
        #2;
        reset = 1;
        #1;
        chk("mid_rst_we", {31'd0, regWrite}, 32'd0);
        chk("mid_rst_dest", {27'd0, regDest}, 32'd0);
        chk("mid_rst_data", writeData, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        tick();
        reset = 0;
        a_valid = 1; a_rd = 12; a_data = 32'hC;
        b_valid = 1; b_rd = 13; b_data = 32'hD;
        #1;
        chk("post_rst_ptrA", {30'd0, a_ready, b_ready}, 32'd2);
        tick();
        idle();
        chk("post_rst_dest", {27'd0, regDest}, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
